// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store over valid/ready
// request and response channels, with a fixed access latency of WAIT_CYCLES.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept_c;
  logic               access_c;
  logic               acc_write_c;
  logic [IDX_W-1:0]   acc_idx_c;
  logic [DATA_W-1:0]  acc_wdata_c;
  logic [DATA_W-1:0]  acc_rdata_c;

  assign req_ready = (state == IDLE);

  // Access source: live request for zero-latency builds, registered request otherwise
  always_comb begin
    accept_c    = req_valid && (state == IDLE);
    access_c    = 1'b0;
    acc_write_c = wr_q;
    acc_idx_c   = idx_q;
    acc_wdata_c = wdata_q;
    if (accept_c && (WAIT_CYCLES == 0) && (req_addr[1:0] == 2'b00)) begin
      access_c    = 1'b1;
      acc_write_c = req_write;
      acc_idx_c   = req_addr[ADDR_W-1:2];
      acc_wdata_c = req_wdata;
    end else if ((state == WAIT) && (cnt == '0)) begin
      access_c = 1'b1;
    end
    acc_rdata_c = mem[acc_idx_c];
  end

  // Storage is deliberately not reset; reset only suppresses a pending write
  always_ff @(posedge clk) begin
    if (!rst && access_c && acc_write_c) begin
      mem[acc_idx_c] <= acc_wdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            wr_q    <= req_write;
            idx_q   <= req_addr[ADDR_W-1:2];
            wdata_q <= req_wdata;
            if (req_addr[1:0] != 2'b00) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= acc_write_c ? '0 : acc_rdata_c;
            end else begin
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= acc_write_c ? '0 : acc_rdata_c;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance,
// directed scenarios plus random traffic against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [7:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int          wc [2] = '{2, 0};
  logic [31:0] mmem [2][64];
  bit          mval [2][64];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at the negedge after the accept edge; waits for resp_valid and checks latency/payload
  task automatic await_resp(input int s, input int exp_edges, input logic [31:0] exp_d, input bit exp_e);
    int edges = 1;
    while (!resp_valid[s] && edges < 40) begin
      check("busy_ready", 32'(req_ready[s]), 32'd0);
      @(negedge clk);
      edges++;
    end
    check("latency", 32'(edges), 32'(exp_edges));
    check("rdata", resp_rdata[s], exp_d);
    check("err", 32'(resp_err[s]), 32'(exp_e));
    check("resp_ready_low", 32'(req_ready[s]), 32'd0);
  endtask

  // Holds the response for 'stall' cycles, then completes the handshake
  task automatic finish_resp(input int s, input int stall);
    logic [31:0] d = resp_rdata[s];
    logic        e = resp_err[s];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(resp_valid[s]), 32'd1);
      check("stall_rdata", resp_rdata[s], d);
      check("stall_err", 32'(resp_err[s]), 32'(e));
      check("stall_ready", 32'(req_ready[s]), 32'd0);
    end
    resp_ready[s] = 1'b1;
    @(negedge clk);
    resp_ready[s] = 1'b0;
    check("post_valid", 32'(resp_valid[s]), 32'd0);
    check("post_rdata", resp_rdata[s], 32'd0);
    check("post_err", 32'(resp_err[s]), 32'd0);
    check("post_ready", 32'(req_ready[s]), 32'd1);
  endtask

  task automatic txn(input int s, input bit w, input logic [7:0] a, input logic [31:0] d, input int stall);
    bit          mis = (a[1:0] != 2'b00);
    int          idx = int'(a[7:2]);
    logic [31:0] exp_d = (mis || w) ? 32'd0 : mmem[s][idx];
    if (!mis && w) begin
      mmem[s][idx] = d;
      mval[s][idx] = 1'b1;
    end
    check("idle_ready", 32'(req_ready[s]), 32'd1);
    req_valid[s] = 1'b1; req_write[s] = w; req_addr[s] = a; req_wdata[s] = d;
    @(negedge clk);
    req_valid[s] = 1'b0;
    await_resp(s, mis ? 1 : wc[s] + 1, exp_d, mis);
    finish_resp(s, stall);
  endtask

  // Held request with resp_ready high: accepts must be wc+2 cycles apart
  task automatic throughput(input int s, input logic [7:0] a);
    int acc[3];
    int nacc = 0;
    resp_ready[s] = 1'b1;
    req_valid[s] = 1'b1; req_write[s] = 1'b0; req_addr[s] = a; req_wdata[s] = 32'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (resp_valid[s]) check("tput_rdata", resp_rdata[s], mmem[s][int'(a[7:2])]);
      if (req_ready[s]) begin
        acc[nacc] = cyc;
        nacc++;
        if (nacc == 3) begin
          req_valid[s] = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    req_valid[s] = 1'b0;
    resp_ready[s] = 1'b0;
    check("tput_count", 32'(nacc), 32'd3);
    if (nacc == 3) begin
      check("tput_gap1", 32'(acc[1] - acc[0]), 32'(wc[s] + 2));
      check("tput_gap2", 32'(acc[2] - acc[1]), 32'(wc[s] + 2));
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_write[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0; resp_ready[s] = 1'b0;
      for (int i = 0; i < 64; i++) mval[s][i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check("rst_valid", 32'(resp_valid[s]), 32'd0);
      check("rst_ready", 32'(req_ready[s]), 32'd1);
      check("rst_rdata", resp_rdata[s], 32'd0);
      check("rst_err", 32'(resp_err[s]), 32'd0);
    end

    // Directed scenarios on the WAIT_CYCLES=2 instance
    txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 0);
    txn(0, 1'b0, 8'h10, 32'h0, 0);
    txn(0, 1'b0, 8'h13, 32'h0, 0);
    txn(0, 1'b0, 8'h10, 32'h0, 0);
    txn(0, 1'b1, 8'h04, 32'h12345678, 0);
    txn(0, 1'b0, 8'h04, 32'h0, 5);

    // Reset during WAIT drops the pending store
    txn(0, 1'b1, 8'h20, 32'h11111111, 0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h20; req_wdata[0] = 32'hAAAA5555;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(resp_valid[0]), 32'd0);
    check("midrst_ready", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 8'h20, 32'h0, 0);

    // Second request held while busy is accepted only once back in IDLE
    begin
      int edges = 1;
      resp_ready[0] = 1'b1;
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h30; req_wdata[0] = 32'hCAFEF00D;
      mmem[0][12] = 32'hCAFEF00D; mval[0][12] = 1'b1;
      @(negedge clk);
      req_write[0] = 1'b0; req_wdata[0] = 32'h0;
      while (!req_ready[0] && edges < 40) begin
        if (resp_valid[0]) check("held_store_rdata", resp_rdata[0], 32'd0);
        @(negedge clk);
        edges++;
      end
      check("held_idle_edge", 32'(edges), 32'(wc[0] + 2));
      resp_ready[0] = 1'b0;
      @(negedge clk);
      req_valid[0] = 1'b0;
      await_resp(0, wc[0] + 1, 32'hCAFEF00D, 1'b0);
      finish_resp(0, 0);
    end
    throughput(0, 8'h10);

    // Zero-latency instance
    txn(1, 1'b1, 8'hFC, 32'hA5A5C3C3, 0);
    txn(1, 1'b0, 8'hFC, 32'h0, 0);
    txn(1, 1'b0, 8'hFE, 32'h0, 1);
    throughput(1, 8'hFC);

    // Random traffic on both instances
    for (int n = 0; n < 60; n++) begin
      int          s = n % 2;
      bit          w = 1'($urandom_range(0, 1));
      logic [5:0]  idx = 6'($urandom_range(0, 63));
      logic [1:0]  lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (lo == 2'b00 && !w && !mval[s][int'(idx)]) w = 1'b1;
      txn(s, w, {idx, lo}, $urandom, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the CPU's load/store port. It accepts one request at a time over a valid/ready request channel and models a configurable access latency. It returns read data, or a write completion, over a valid/ready response channel. It sits between the CPU's memory stage (MemRead/MemWrite, ALU-result address, rt write data) and a word-organised storage array. It replaces the zero-latency combinational data memory when the pipeline is run against a slow memory.

## Interface
- ADDR_W, 8, byte address width; storage holds 2^(ADDR_W-2) 32-bit words.
- DATA_W, 32, data width; only 32 is supported.
- WAIT_CYCLES, 2, extra cycles between request acceptance and the access; legal range 0..15.

Reset is synchronous and active-high.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_write  in  1  1 = store (MemWrite), 0 = load (MemRead).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  DATA_W  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned; no access performed.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. Reset enters IDLE.
- **IDLE:** req_ready=1.
  - Acceptance happens when req_valid && req_ready on an edge.
  - On acceptance, req_write, req_addr and req_wdata are registered.
  - If req_addr[1:0]!=0, the FSM goes to RESP with resp_err=1 and resp_rdata=0. Storage is untouched.
  - Else, if WAIT_CYCLES==0, the access is performed on the accept edge and the FSM goes to RESP.
  - Else, the wait counter is loaded with WAIT_CYCLES-1 and the FSM goes to WAIT.
- **WAIT:** req_ready=0.
  - If the counter is nonzero, it decrements.
  - If the counter is 0, the access is performed on this edge and the FSM goes to RESP.
- **Access:**
  - Word index = addr[ADDR_W-1:2].
  - A store writes the registered wdata to mem[index] and sets resp_rdata=0.
  - A load latches resp_rdata = mem[index], the value before any write on the same edge.
- **RESP:** resp_valid=1. resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - On that handshake edge, the FSM returns to IDLE.
  - On the same edge, resp_valid, resp_err and resp_rdata clear to 0.
- Only one request is ever outstanding. A request arriving while not in IDLE is not accepted; the requester holds it.
- Storage contents are not reset, and no reset cycle is required before a first write. Loads from never-written words return X in simulation. Benches must write before reading.

## Timing
- **Reset values:**
  - State = IDLE, so req_ready=1 in the cycle after the reset edge.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - Wait counter = 0.
- **Latency:** resp_valid rises WAIT_CYCLES+1 edges after the accept edge.
  - Misaligned requests always respond 1 edge after accept, regardless of WAIT_CYCLES.
- **Throughput:** with resp_ready held high, one transaction completes every WAIT_CYCLES+2 cycles. The IDLE cycle after the response is mandatory, so there is no back-to-back accept on the response-handshake edge.
- **Reset mid-operation:** rst has priority over all other events.
  - In WAIT, the pending store is discarded and storage is unchanged.
  - In RESP, the response is dropped.
  - Stores already performed persist.
- **Backpressure:** resp_ready low holds RESP indefinitely with outputs stable. req_ready stays 0 for the whole stall.
- **Address wrap:** the address is ADDR_W bits wide, so it cannot go out of range and there is no wrap logic.

## Test plan
- **Reset then aligned store/load, WAIT_CYCLES=2:**
  - Store 0xDEADBEEF to addr 0x10.
  - Then load addr 0x10.
  - Required response: resp_rdata=0xDEADBEEF and resp_err=0.
  - resp_valid rises exactly 3 edges after each accept; req_ready=0 from accept until return to IDLE.
- **Misaligned request:**
  - Load addr 0x13.
  - Required response: resp_valid 1 edge after accept, resp_err=1, resp_rdata=0.
  - A following load of 0x10 still returns the previously stored value, proving the storage was untouched.
- **Response backpressure:**
  - Hold resp_ready=0 for 5 cycles during a load of 0x04 (previously stored 0x12345678).
  - Required response: resp_valid, resp_rdata and resp_err stable for all 5 cycles; req_ready=0 throughout.
  - The FSM returns to IDLE one edge after resp_ready rises.
- **Reset mid-WAIT:**
  - Store 0xAAAA5555 to addr 0x20 (old value 0x11111111), and assert rst during WAIT.
  - Required response: after reset, a load of 0x20 returns 0x11111111; resp_valid=0 and req_ready=1 right after reset.
- **WAIT_CYCLES=0 build:**
  - Run a store/load to addr 0xFC.
  - Required response: resp_valid 1 edge after accept.
  - Back-to-back transactions with resp_ready=1 complete every 2 cycles.
- **Request held while busy:**
  - Keep req_valid=1 with a second load during WAIT and RESP of a first store.
  - Required response: the second request is accepted only on the first IDLE edge.
  - It returns the data written by the first store.
